stepper_motion_ctrl: RTL

//  Parametrised stepper motion controller; successor to the fixed-rate PMOD stepper interface.

---
 rtl/stepper_motion_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/stepper_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stepper_motion_ctrl
// Description : Stepper motion controller. Moves are accepted over a
//               valid/ready handshake as (steps, dir, period, mode). The step
//               rate ramps from a start period down to the commanded period.
//               The controller drives 4 coil lines in wave, full or half step
//               and tracks a signed absolute position.
// Ports       : clk, rst_n (async, active-low)
//               en                 driver enable (0 = coils off, abort move)
//               cmd_valid/ready    command handshake
//               cmd_dir/mode/steps/period  command fields
//               abort              stop the current move
//               busy, done, step_pulse     status
//               position           signed step count
//               signal_out[3:0]    registered coil drive
// Revision    : 1.0 - initial release
// ============================================================================
module stepper_motion_ctrl #(
   parameter int CNT_W        = 24,
   parameter int STEP_W       = 16,
   parameter int POS_W        = 32,
   parameter int START_PERIOD = 200000,
   parameter int RAMP_DEC     = 1000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_dir,
   input  logic [1:0]        cmd_mode,
   input  logic [STEP_W-1:0] cmd_steps,
   input  logic [CNT_W-1:0]  cmd_period,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              step_pulse,
   output logic [POS_W-1:0]  position,
   output logic [3:0]        signal_out
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [CNT_W-1:0] c_start = CNT_W'(START_PERIOD);
   localparam logic [CNT_W-1:0] c_dec   = CNT_W'(RAMP_DEC);
   localparam logic [CNT_W-1:0] c_min   = CNT_W'(2);

   logic [1:0]        r_state;
   logic [2:0]        r_idx;
   logic              r_dir;
   logic              r_half;
   logic [CNT_W-1:0]  r_tgt;
   logic [CNT_W-1:0]  r_cur;
   logic [CNT_W-1:0]  r_timer;
   logic [STEP_W-1:0] r_remaining;
   logic [POS_W-1:0]  r_pos;
   logic [3:0]        r_signal;
   logic              r_step_pulse;

   logic              w_accept;
   logic              w_step;
   logic [CNT_W-1:0]  w_tgt;
   logic [CNT_W-1:0]  w_cur0;
   logic [CNT_W:0]    w_floor;
   logic [CNT_W-1:0]  w_cur_ramped;
   logic [2:0]        w_inc;
   logic [2:0]        w_idx_next;
   logic [3:0]        w_phase;

   assign cmd_ready  = (r_state == S_IDLE) && en;
   assign busy       = (r_state == S_RUN);
   assign done       = (r_state == S_DONE);
   assign step_pulse = r_step_pulse;
   assign position   = r_pos;
   assign signal_out = r_signal;

   assign w_accept = cmd_valid && cmd_ready;
   assign w_step   = (r_state == S_RUN) && (r_timer == '0);

   // Target period is floored at 2 so the reload value cur-1 is never 0.
   assign w_tgt  = (cmd_period < c_min) ? c_min : cmd_period;
   assign w_cur0 = (RAMP_DEC == 0) ? w_tgt : ((c_start > w_tgt) ? c_start : w_tgt);

   // Ramp: cur-RAMP_DEC, but never below the target and never wrapping.
   assign w_floor      = {1'b0, r_tgt} + {1'b0, c_dec};
   assign w_cur_ramped = ({1'b0, r_cur} >= w_floor) ? (r_cur - c_dec) : r_tgt;

   assign w_inc = r_half ? 3'd1 : 3'd2;

   // Next phase index: realigned on accept so wave sits on single-coil
   // (even) phases and full on two-coil (odd) phases; 3-bit wrap gives mod 8.
   always_comb begin
      w_idx_next = r_idx;
      if (w_accept) begin
         case (cmd_mode)
            2'b00:   w_idx_next = {r_idx[2:1], 1'b0};
            2'b01:   w_idx_next = {r_idx[2:1], 1'b1};
            default: w_idx_next = r_idx;
         endcase
      end else if (w_step) begin
         w_idx_next = r_dir ? (r_idx + w_inc) : (r_idx - w_inc);
      end
   end

   always_comb begin
      w_phase = 4'b1000;
      case (w_idx_next)
         3'd0:    w_phase = 4'b1000;
         3'd1:    w_phase = 4'b1100;
         3'd2:    w_phase = 4'b0100;
         3'd3:    w_phase = 4'b0110;
         3'd4:    w_phase = 4'b0010;
         3'd5:    w_phase = 4'b0011;
         3'd6:    w_phase = 4'b0001;
         default: w_phase = 4'b1001;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_idx        <= 3'd0;
         r_dir        <= 1'b0;
         r_half       <= 1'b0;
         r_tgt        <= c_min;
         r_cur        <= c_min;
         r_timer      <= '0;
         r_remaining  <= '0;
         r_pos        <= '0;
         r_signal     <= 4'b0000;
         r_step_pulse <= 1'b0;
      end else begin
         r_idx        <= w_idx_next;
         r_signal     <= en ? w_phase : 4'b0000;
         r_step_pulse <= w_step;

         if (w_step) begin
            r_pos <= r_dir ? (r_pos + POS_W'(1)) : (r_pos - POS_W'(1));
         end

         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_dir       <= cmd_dir;
                  r_half      <= cmd_mode[1];
                  r_tgt       <= w_tgt;
                  r_cur       <= w_cur0;
                  r_timer     <= w_cur0 - CNT_W'(1);
                  r_remaining <= cmd_steps;
                  r_state     <= (cmd_steps == '0) ? S_DONE : S_RUN;
               end
            end
            S_RUN: begin
               if (w_step) begin
                  r_remaining <= r_remaining - STEP_W'(1);
                  r_cur       <= w_cur_ramped;
                  r_timer     <= w_cur_ramped - CNT_W'(1);
               end else begin
                  r_timer <= r_timer - CNT_W'(1);
               end
               // A step falling on the abort edge is still taken above.
               if ((w_step && (r_remaining == STEP_W'(1))) || abort || !en) begin
                  r_state <= S_DONE;
               end
            end
            S_DONE: r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
